// File: rtl/risc_v_mike_pkg.sv
// Shared types for the risc_v_mike decode slice: immediate format codes,
// skid-buffer occupancy states and the stored result entry layout.
package risc_v_mike_pkg;

    localparam int INSTR_32_W      = 32;
    localparam int IMM_FMT_W       = 3;
    localparam int IMM_ENTRY_XLEN  = 32;
    localparam int IMM_ENTRY_TAG_W = 5;

    typedef enum logic [IMM_FMT_W-1:0] {
        IMM_I     = 3'd0,
        IMM_S     = 3'd1,
        IMM_B     = 3'd2,
        IMM_J     = 3'd3,
        IMM_U     = 3'd4,
        IMM_SHAMT = 3'd5,
        IMM_ZIMM  = 3'd6,
        IMM_ILL   = 3'd7
    } imm_fmt_e;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_e;

    // Layout of one stored result at the default widths; the pipelined top
    // mirrors this field order with its own parameterised widths.
    typedef struct packed {
        logic [IMM_ENTRY_XLEN-1:0]  imm;
        logic                       err;
        logic [IMM_ENTRY_TAG_W-1:0] tag;
    } imm_entry_t;

endpackage

// File: rtl/risc_v_mike_imm_decode.sv
// Combinational immediate extraction for all RV formats, extended to XLEN.
// Format code 7 yields zero with the error flag raised.
module risc_v_mike_imm_decode
    import risc_v_mike_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [INSTR_32_W-1:0] instr,
    input  imm_fmt_e              fmt,
    output logic [XLEN-1:0]       imm,
    output logic                  err
);

    // RV64 shifts use a 6-bit shamt, RV32 a 5-bit one.
    localparam int SH_W = (XLEN == 64) ? 6 : 5;

    // Opcode bits never contribute to an immediate.
    logic unused_opcode_s;
    assign unused_opcode_s = ^instr[6:0];

    // Field extraction and sign/zero extension per format.
    always_comb begin
        imm = '0;
        err = 1'b0;
        case (fmt)
            IMM_I:     imm = {{(XLEN-11){instr[31]}}, instr[30:20]};
            IMM_S:     imm = {{(XLEN-11){instr[31]}}, instr[30:25], instr[11:7]};
            IMM_B:     imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:     imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_U:     imm = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
            IMM_SHAMT: imm = {{(XLEN-SH_W){1'b0}}, instr[20+SH_W-1:20]};
            IMM_ZIMM:  imm = {{(XLEN-5){1'b0}}, instr[19:15]};
            IMM_ILL: begin
                imm = '0;
                err = 1'b1;
            end
            default: begin
                imm = '0;
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/risc_v_mike_imm_gen_pipe.sv
// Pipelined immediate generator: combinational decode feeding a main output
// register backed by one skid entry, valid/ready on both sides.
module risc_v_mike_imm_gen_pipe
    import risc_v_mike_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INSTR_32_W-1:0] in_instr,
    input  logic [IMM_FMT_W-1:0]  in_imm_src,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_imm,
    output logic                  out_err,
    output logic [TAG_W-1:0]      out_tag
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic             err;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t     new_s;
    entry_t     main_r;
    entry_t     skid_r;
    occ_state_e state_r;
    occ_state_e state_next_s;
    logic       in_ready_r;
    logic       out_valid_r;
    logic       accept_s;
    logic       drain_s;
    logic       load_main_new_s;
    logic       load_main_skid_s;
    logic       load_skid_s;
    logic [XLEN-1:0] dec_imm_s;
    logic            dec_err_s;

    risc_v_mike_imm_decode #(.XLEN(XLEN)) u_decode (
        .instr (in_instr),
        .fmt   (imm_fmt_e'(in_imm_src)),
        .imm   (dec_imm_s),
        .err   (dec_err_s)
    );

    assign new_s     = '{imm: dec_imm_s, err: dec_err_s, tag: in_tag};
    assign accept_s  = in_valid & in_ready_r;
    assign drain_s   = out_valid_r & out_ready;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_imm   = main_r.imm;
    assign out_err   = main_r.err;
    assign out_tag   = main_r.tag;

    // Occupancy next-state and register load selects.
    always_comb begin
        state_next_s     = state_r;
        load_main_new_s  = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        case (state_r)
            OCC_EMPTY: begin
                if (accept_s) begin
                    state_next_s    = OCC_ONE;
                    load_main_new_s = 1'b1;
                end else begin
                    state_next_s = OCC_EMPTY;
                end
            end
            OCC_ONE: begin
                if (accept_s && drain_s) begin
                    state_next_s    = OCC_ONE;
                    load_main_new_s = 1'b1;
                end else if (accept_s) begin
                    state_next_s = OCC_TWO;
                    load_skid_s  = 1'b1;
                end else if (drain_s) begin
                    state_next_s = OCC_EMPTY;
                end else begin
                    state_next_s = OCC_ONE;
                end
            end
            OCC_TWO: begin
                // in_ready is low here, so only a drain can move us.
                if (drain_s) begin
                    state_next_s     = OCC_ONE;
                    load_main_skid_s = 1'b1;
                end else begin
                    state_next_s = OCC_TWO;
                end
            end
            default: begin
                state_next_s = OCC_EMPTY;
            end
        endcase
    end

    // State register; handshake flags are registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= OCC_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s != OCC_TWO);
            out_valid_r <= (state_next_s != OCC_EMPTY);
        end
    end

    // Main output and skid entry storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_r <= '0;
            skid_r <= '0;
        end else begin
            if (load_main_new_s) begin
                main_r <= new_s;
            end else if (load_main_skid_s) begin
                main_r <= skid_r;
            end
            if (load_skid_s) begin
                skid_r <= new_s;
            end
        end
    end

endmodule

// File: tb/tb_risc_v_mike_imm_gen_pipe.sv
// Directed bench for the immediate generator at XLEN=32 and XLEN=64.
module tb_risc_v_mike_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid32, in_ready32, out_valid32, out_ready32, out_err32;
    logic [31:0] in_instr32, out_imm32;
    logic [2:0]  in_src32;
    logic [4:0]  in_tag32, out_tag32;

    logic        in_valid64, in_ready64, out_valid64, out_ready64, out_err64;
    logic [31:0] in_instr64;
    logic [63:0] out_imm64;
    logic [2:0]  in_src64;
    logic [4:0]  in_tag64, out_tag64;

    int n_vec = 0;
    int n_miscmp = 0;

    always #5 clk = ~clk;

    risc_v_mike_imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid32), .in_ready(in_ready32), .in_instr(in_instr32),
        .in_imm_src(in_src32), .in_tag(in_tag32),
        .out_valid(out_valid32), .out_ready(out_ready32), .out_imm(out_imm32),
        .out_err(out_err32), .out_tag(out_tag32)
    );

    risc_v_mike_imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid64), .in_ready(in_ready64), .in_instr(in_instr64),
        .in_imm_src(in_src64), .in_tag(in_tag64),
        .out_valid(out_valid64), .out_ready(out_ready64), .out_imm(out_imm64),
        .out_err(out_err64), .out_tag(out_tag64)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transfer through the 32-bit instance with the consumer ready.
    task automatic xfer32(input string tag, input logic [31:0] ins, input logic [2:0] src,
                          input logic [31:0] exp_imm, input logic exp_err);
        in_valid32 = 1'b1; in_instr32 = ins; in_src32 = src; in_tag32 = 5'd9;
        step();
        in_valid32 = 1'b0;
        check_val({tag, "_valid"}, {63'd0, out_valid32}, 64'd1);
        check_val({tag, "_imm"}, {32'd0, out_imm32}, {32'd0, exp_imm});
        check_val({tag, "_err"}, {63'd0, out_err32}, {63'd0, exp_err});
        step();
    endtask

    task automatic xfer64(input string tag, input logic [31:0] ins, input logic [2:0] src,
                          input logic [63:0] exp_imm, input logic exp_err);
        in_valid64 = 1'b1; in_instr64 = ins; in_src64 = src; in_tag64 = 5'd17;
        step();
        in_valid64 = 1'b0;
        check_val({tag, "_imm"}, out_imm64, exp_imm);
        check_val({tag, "_err"}, {63'd0, out_err64}, {63'd0, exp_err});
        check_val({tag, "_tag"}, {59'd0, out_tag64}, 64'd17);
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid32 = 1'b0; in_instr32 = 32'd0; in_src32 = 3'd0; in_tag32 = 5'd0; out_ready32 = 1'b1;
        in_valid64 = 1'b0; in_instr64 = 32'd0; in_src64 = 3'd0; in_tag64 = 5'd0; out_ready64 = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        check_val("rst_out_valid", {63'd0, out_valid32}, 64'd0);
        check_val("rst_out_imm", {32'd0, out_imm32}, 64'd0);
        check_val("rst_out_err", {63'd0, out_err32}, 64'd0);
        check_val("rst_out_tag", {59'd0, out_tag32}, 64'd0);
        check_val("rst_in_ready", {63'd0, in_ready32}, 64'd1);

        // XLEN=32 formats
        xfer32("i_addi", 32'hFFF00093, 3'd0, 32'hFFFFFFFF, 1'b0);
        xfer32("s_sw", 32'hFE112E23, 3'd1, 32'hFFFFFFFC, 1'b0);
        xfer32("b_beq", 32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 1'b0);
        xfer32("j_pos", 32'h0080006F, 3'd3, 32'h00000008, 1'b0);
        xfer32("j_neg", 32'hFFDFF0EF, 3'd3, 32'hFFFFFFFC, 1'b0);
        xfer32("u_lui", 32'h123450B7, 3'd4, 32'h12345000, 1'b0);
        xfer32("sh32_max", 32'h01F09093, 3'd5, 32'h0000001F, 1'b0);
        xfer32("sh32_bit25", 32'h03F09093, 3'd5, 32'h0000001F, 1'b0);
        xfer32("zimm", 32'h000FD073, 3'd6, 32'h0000001F, 1'b0);
        xfer32("ill32", 32'hFFFFFFFF, 3'd7, 32'h00000000, 1'b1);

        // XLEN=64 formats
        xfer64("u64", 32'h800000B7, 3'd4, 64'hFFFFFFFF80000000, 1'b0);
        xfer64("sh64", 32'h03F09093, 3'd5, 64'h000000000000003F, 1'b0);
        xfer64("i64", 32'hFFF00093, 3'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        xfer64("ill64", 32'h123450B7, 3'd7, 64'h0, 1'b1);

        // Backpressure: tags 1,2,3 with imm equal to tag
        out_ready32 = 1'b0;
        in_src32 = 3'd0;
        in_valid32 = 1'b1; in_tag32 = 5'd1; in_instr32 = 32'h00100093;
        step();
        check_val("bp_rdy_after1", {63'd0, in_ready32}, 64'd1);
        in_tag32 = 5'd2; in_instr32 = 32'h00200093;
        step();
        check_val("bp_rdy_after2", {63'd0, in_ready32}, 64'd0);
        in_tag32 = 5'd3; in_instr32 = 32'h00300093;
        step();
        check_val("bp_stall_valid", {63'd0, out_valid32}, 64'd1);
        check_val("bp_stall_tag", {59'd0, out_tag32}, 64'd1);
        check_val("bp_stall_imm", {32'd0, out_imm32}, 64'd1);
        check_val("bp_stall_rdy", {63'd0, in_ready32}, 64'd0);
        step();
        check_val("bp_stable_tag", {59'd0, out_tag32}, 64'd1);
        check_val("bp_stable_imm", {32'd0, out_imm32}, 64'd1);
        out_ready32 = 1'b1;
        step();
        check_val("bp_out2_tag", {59'd0, out_tag32}, 64'd2);
        check_val("bp_out2_imm", {32'd0, out_imm32}, 64'd2);
        check_val("bp_rdy_back", {63'd0, in_ready32}, 64'd1);
        step();
        in_valid32 = 1'b0;
        check_val("bp_out3_tag", {59'd0, out_tag32}, 64'd3);
        check_val("bp_out3_imm", {32'd0, out_imm32}, 64'd3);
        check_val("bp_out3_valid", {63'd0, out_valid32}, 64'd1);
        step();
        check_val("bp_drained", {63'd0, out_valid32}, 64'd0);

        // Streaming: 16 back-to-back with consumer always ready
        for (int i = 0; i < 16; i++) begin
            in_valid32 = 1'b1; in_tag32 = 5'(i); in_src32 = 3'd0;
            in_instr32 = {12'(i + 100), 20'h00093};
            step();
            check_val("st_valid", {63'd0, out_valid32}, 64'd1);
            check_val("st_tag", {59'd0, out_tag32}, 64'(i));
            check_val("st_imm", {32'd0, out_imm32}, 64'(i + 100));
            check_val("st_rdy", {63'd0, in_ready32}, 64'd1);
        end
        in_valid32 = 1'b0;
        step();
        check_val("st_end_valid", {63'd0, out_valid32}, 64'd0);

        // Reset while two entries are held
        out_ready32 = 1'b0;
        in_valid32 = 1'b1; in_tag32 = 5'd20; in_instr32 = 32'h01400093;
        step();
        in_tag32 = 5'd21; in_instr32 = 32'h01500093;
        step();
        in_valid32 = 1'b0;
        check_val("two_rdy", {63'd0, in_ready32}, 64'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_val("rst2_valid", {63'd0, out_valid32}, 64'd0);
        check_val("rst2_rdy", {63'd0, in_ready32}, 64'd1);
        check_val("rst2_tag", {59'd0, out_tag32}, 64'd0);
        out_ready32 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_val("rst2_no_stale", {63'd0, out_valid32}, 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
